// File: rtl/fft4_pkg.sv
// Shared types and constants for the 4-point radix-2 DIT FFT datapath.
// Used by the input reorder stage and the later butterfly/twiddle/output stages.
package fft4_pkg;

    localparam int FFT_N = 4;
    localparam int DW    = 2;
    localparam int PAIRS = FFT_N / 2;

    typedef logic signed [DW-1:0] sample_t;
    typedef logic                 pair_idx_t;
    typedef logic [3:0]           frame_tag_t;

endpackage

// File: rtl/fft4_input_reorder_if.sv
// Sample-in / operand-pair-out stream bundle for the FFT input reorder stage.
// The out_tag signal exists only when FFT4_REORDER_FRAME_TAG_EN is defined.
interface fft4_input_reorder_if #(parameter int DW = fft4_pkg::DW);

    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_a;
    logic signed [DW-1:0] out_b;
    logic                 out_pair;
    logic                 out_last;
`ifdef FFT4_REORDER_FRAME_TAG_EN
    logic [3:0]           out_tag;

    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_a, out_b, out_pair, out_last, out_tag);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_a, out_b, out_pair, out_last, out_tag);
`else
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_a, out_b, out_pair, out_last);
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_a, out_b, out_pair, out_last);
`endif

endinterface

// File: rtl/fft4_bank.sv
// One ping-pong bank: 4-entry sample register file with a full flag and
// two combinational read ports returning x[p] and x[p+2].
module fft4_bank
    import fft4_pkg::*;
#(
    parameter int DW = fft4_pkg::DW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [1:0]           widx_i,
    input  logic signed [DW-1:0] wdata_i,
    input  logic                 set_full_i,
    input  logic                 clr_full_i,
    input  pair_idx_t            rp_i,
    output logic signed [DW-1:0] rd_a_o,
    output logic signed [DW-1:0] rd_b_o,
    output logic                 full_o
);

    logic signed [DW-1:0] mem_q [FFT_N];
    logic                 full_q;
    logic                 full_d;

    // Fill-complete and drain-complete never target the same bank in one cycle.
    always_comb begin
        full_d = full_q;
        if (set_full_i) begin
            full_d = 1'b1;
        end else if (clr_full_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FFT_N; i++) begin
                mem_q[i] <= '0;
            end
            full_q <= 1'b0;
        end else begin
            if (we_i) begin
                mem_q[widx_i] <= wdata_i;
            end
            full_q <= full_d;
        end
    end

    assign rd_a_o = mem_q[{1'b0, rp_i}];
    assign rd_b_o = mem_q[{1'b1, rp_i}];
    assign full_o = full_q;

endmodule

// File: rtl/fft4_input_reorder.sv
// Ping-pong input staging for the 4-point DIT FFT: collects 4 serial samples
// per frame and emits (x0,x2) then (x1,x3). Optional: FFT4_REORDER_FRAME_TAG_EN.
module fft4_input_reorder
    import fft4_pkg::*;
#(
    parameter int DW = fft4_pkg::DW,
    parameter int N  = 4
) (
    input logic                  clk,
    input logic                  rst_n,
    fft4_input_reorder_if.slave  bus
);

    if (N != FFT_N) begin : g_bad_n
        $error("fft4_input_reorder supports only N == 4");
    end

    logic                 wr_bank_q, wr_bank_d;
    logic [1:0]           wr_idx_q,  wr_idx_d;
    logic                 rd_bank_q, rd_bank_d;
    pair_idx_t            rd_pair_q, rd_pair_d;

    logic                 full   [2];
    logic signed [DW-1:0] bank_a [2];
    logic signed [DW-1:0] bank_b [2];

    logic accept, fill_done, drain, drain_done;

    assign accept     = bus.in_valid && bus.in_ready;
    assign fill_done  = accept && (wr_idx_q == 2'd3);
    assign drain      = bus.out_valid && bus.out_ready;
    assign drain_done = drain && rd_pair_q;

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft4_bank #(.DW(DW)) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .we_i       (accept && (wr_bank_q == 1'(g))),
            .widx_i     (wr_idx_q),
            .wdata_i    (bus.in_data),
            .set_full_i (fill_done && (wr_bank_q == 1'(g))),
            .clr_full_i (drain_done && (rd_bank_q == 1'(g))),
            .rp_i       (rd_pair_q),
            .rd_a_o     (bank_a[g]),
            .rd_b_o     (bank_b[g]),
            .full_o     (full[g])
        );
    end

    always_comb begin
        wr_bank_d = wr_bank_q;
        wr_idx_d  = wr_idx_q;
        rd_bank_d = rd_bank_q;
        rd_pair_d = rd_pair_q;
        if (accept) begin
            wr_idx_d = wr_idx_q + 2'd1;
            if (fill_done) begin
                wr_bank_d = ~wr_bank_q;
            end
        end
        if (drain) begin
            rd_pair_d = ~rd_pair_q;
            if (drain_done) begin
                rd_bank_d = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= 1'b0;
            wr_idx_q  <= 2'd0;
            rd_bank_q <= 1'b0;
            rd_pair_q <= 1'b0;
        end else begin
            wr_bank_q <= wr_bank_d;
            wr_idx_q  <= wr_idx_d;
            rd_bank_q <= rd_bank_d;
            rd_pair_q <= rd_pair_d;
        end
    end

    // All outputs derive from registered state only, so they hold under stall.
    assign bus.in_ready  = !full[wr_bank_q];
    assign bus.out_valid = full[rd_bank_q];
    assign bus.out_a     = bank_a[rd_bank_q];
    assign bus.out_b     = bank_b[rd_bank_q];
    assign bus.out_pair  = rd_pair_q;
    assign bus.out_last  = rd_pair_q;

`ifdef FFT4_REORDER_FRAME_TAG_EN
    frame_tag_t tag_cnt_q, tag_cnt_d;
    frame_tag_t tag_q [2];

    always_comb begin
        tag_cnt_d = tag_cnt_q;
        if (fill_done) begin
            tag_cnt_d = tag_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_cnt_q <= '0;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
        end else begin
            tag_cnt_q <= tag_cnt_d;
            if (fill_done) begin
                tag_q[wr_bank_q] <= tag_cnt_q;
            end
        end
    end

    assign bus.out_tag = tag_q[rd_bank_q];
`endif

endmodule

// File: tb/tb_fft4_input_reorder.sv
// Directed self-checking bench for fft4_input_reorder (DW=2).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fft4_input_reorder;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    fft4_input_reorder_if #(.DW(2)) bus ();

    fft4_input_reorder #(.DW(2), .N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [1:0] ra[$];
    logic signed [1:0] rb[$];
    logic              rp[$];

    function automatic logic signed [1:0] s2(input int v);
        return v[1:0];
    endfunction

    function automatic logic [6:0] obs();
        return {bus.out_valid, bus.out_a, bus.out_b, bus.out_pair, bus.out_last};
    endfunction

    function automatic logic [6:0] expv(input logic v, input int a, input int b, input logic p);
        return {v, s2(a), s2(b), p, p};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 7'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_held: got out=%b rdy=%b expected out=0000000 rdy=1", obs(), bus.in_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== 7'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_released: got out=%b rdy=%b expected out=0000000 rdy=1", obs(), bus.in_ready);
        end
    endtask

    task automatic test_basic();
        int d[4] = '{1, -1, 0, -2};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL basic_fill%0d: got rdy=%b vld=%b expected rdy=1 vld=0", i, bus.in_ready, bus.out_valid);
            end
            bus.in_valid = 1'b1;
            bus.in_data = s2(d[i]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== expv(1'b1, 1, 0, 1'b0)) begin
            errors++;
            $display("FAIL basic_pair0: got %b expected %b", obs(), expv(1'b1, 1, 0, 1'b0));
        end
        @(negedge clk);
        checks++;
        if (obs() !== expv(1'b1, -1, -2, 1'b1)) begin
            errors++;
            $display("FAIL basic_pair1: got %b expected %b", obs(), expv(1'b1, -1, -2, 1'b1));
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_empty: got vld=%b expected vld=0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int d[8]  = '{0, 1, -2, -1, 1, 1, -1, -1};
        int ea[4] = '{0, 1, 1, 1};
        int eb[4] = '{-2, -1, -1, -1};
        logic ep[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        ra.delete(); rb.delete(); rp.delete();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                ra.push_back(bus.out_a); rb.push_back(bus.out_b); rp.push_back(bus.out_pair);
            end
            if (c < 8) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready%0d: got %b expected 1", c, bus.in_ready);
                end
                bus.in_valid = 1'b1;
                bus.in_data = s2(d[c]);
            end else begin
                bus.in_valid = 1'b0;
            end
        end
        checks++;
        if (ra.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d pairs expected 4", ra.size());
        end
        for (int i = 0; i < ra.size() && i < 4; i++) begin
            checks++;
            if (ra[i] !== s2(ea[i]) || rb[i] !== s2(eb[i]) || rp[i] !== ep[i]) begin
                errors++;
                $display("FAIL b2b_pair%0d: got a=%0d b=%0d p=%b expected a=%0d b=%0d p=%b",
                         i, ra[i], rb[i], rp[i], s2(ea[i]), s2(eb[i]), ep[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int d[12] = '{1, 0, -1, -2, -2, 1, 0, -1, 0, 0, 1, 1};
        int ea[6] = '{1, 0, -2, 1, 0, 0};
        int eb[6] = '{-1, -2, 0, -1, 1, 1};
        logic ep[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        int k = 0;
        ra.delete(); rb.delete(); rp.delete();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c >= 5) begin
                checks++;
                if (obs() !== expv(1'b1, 1, -1, 1'b0)) begin
                    errors++;
                    $display("FAIL bp_hold%0d: got %b expected %b", c, obs(), expv(1'b1, 1, -1, 1'b0));
                end
            end
            bus.in_valid = 1'b1;
            if (bus.in_ready) begin
                bus.in_data = s2(d[k]);
                k++;
            end else begin
                bus.in_data = ~s2(d[k]);
            end
        end
        checks++;
        if (k != 8 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accepts: got %0d rdy=%b expected 8 rdy=0", k, bus.in_ready);
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            if (bus.out_valid) begin
                ra.push_back(bus.out_a); rb.push_back(bus.out_b); rp.push_back(bus.out_pair);
            end
            if (k < 12) begin
                bus.in_valid = 1'b1;
                if (bus.in_ready) begin
                    bus.in_data = s2(d[k]);
                    k++;
                end else begin
                    bus.in_data = ~s2(d[k]);
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            if (ra.size() >= 6 && k == 12) break;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (ra.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d pairs expected 6", ra.size());
        end
        for (int i = 0; i < ra.size() && i < 6; i++) begin
            checks++;
            if (ra[i] !== s2(ea[i]) || rb[i] !== s2(eb[i]) || rp[i] !== ep[i]) begin
                errors++;
                $display("FAIL bp_pair%0d: got a=%0d b=%0d p=%b expected a=%0d b=%0d p=%b",
                         i, ra[i], rb[i], rp[i], s2(ea[i]), s2(eb[i]), ep[i]);
            end
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drained: got vld=%b rdy=%b expected vld=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_stall_toggle();
        int d[4] = '{-1, 1, -2, 0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data = s2(d[i]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== expv(1'b1, -1, -2, 1'b0)) begin
            errors++;
            $display("FAIL stall_first: got %b expected %b", obs(), expv(1'b1, -1, -2, 1'b0));
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs() !== expv(1'b1, -1, -2, 1'b0)) begin
            errors++;
            $display("FAIL stall_held: got %b expected %b", obs(), expv(1'b1, -1, -2, 1'b0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs() !== expv(1'b1, 1, 0, 1'b1)) begin
            errors++;
            $display("FAIL stall_pair1: got %b expected %b", obs(), expv(1'b1, 1, 0, 1'b1));
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_empty: got vld=%b expected vld=0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int f1[4] = '{1, 0, 1, 0};
        int f3[4] = '{-2, -1, 1, 0};
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data = s2(f1[i]);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_data = s2(1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++;
        if (obs() !== expv(1'b1, 0, 0, 1'b1)) begin
            errors++;
            $display("FAIL rstmid_middrain: got %b expected %b", obs(), expv(1'b1, 0, 0, 1'b1));
        end
        bus.in_data = s2(-1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs() !== 7'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_async: got out=%b rdy=%b expected out=0000000 rdy=1", obs(), bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data = s2(f3[i]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (obs() !== expv(1'b1, -2, 1, 1'b0)) begin
            errors++;
            $display("FAIL rstmid_pair0: got %b expected %b", obs(), expv(1'b1, -2, 1, 1'b0));
        end
        @(negedge clk);
        checks++;
        if (obs() !== expv(1'b1, -1, 0, 1'b1)) begin
            errors++;
            $display("FAIL rstmid_pair1: got %b expected %b", obs(), expv(1'b1, -1, 0, 1'b1));
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_empty: got vld=%b expected vld=0", bus.out_valid);
        end
    endtask

`ifdef FFT4_REORDER_FRAME_TAG_EN
    task automatic test_frame_tag();
        logic [3:0] tags[$];
        int sent = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.out_valid) tags.push_back(bus.out_tag);
            if (sent < 68) begin
                bus.in_valid = 1'b1;
                bus.in_data = s2(sent);
                sent++;
            end else begin
                bus.in_valid = 1'b0;
            end
            if (tags.size() >= 34) break;
        end
        bus.in_valid = 1'b0;
        checks++;
        if (tags.size() != 34) begin
            errors++;
            $display("FAIL tag_count: got %0d pairs expected 34", tags.size());
        end
        for (int i = 0; i < tags.size() && i < 34; i++) begin
            checks++;
            if (tags[i] !== 4'((i / 2) % 16)) begin
                errors++;
                $display("FAIL tag_pair%0d: got %0d expected %0d", i, tags[i], (i / 2) % 16);
            end
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_stall_toggle();
        test_reset_mid();
`ifdef FFT4_REORDER_FRAME_TAG_EN
        test_frame_tag();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
